// File: rtl/axis_checker_pkg.sv
// rtl/axis_checker_pkg.sv - shared types for the AXI-Stream golden-compare checker
//
// Purpose : FSM state encoding and status record types used by axis_stream_checker.
// Ports   : none (package).
package axis_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } checker_state_e;

    localparam int STATUS_CNT_WIDTH = 32;

    // Flag portion of the status; kept registered inside the checker.
    typedef struct packed {
        logic busy;
        logic finished;
        logic failed;
        logic length_error;
        logic timeout;
    } status_flags_t;

    // Full status snapshot at the default counter width, for consumers
    // that want to carry the whole result as one record.
    typedef struct packed {
        status_flags_t                flags;
        logic [STATUS_CNT_WIDTH-1:0]  word_count;
        logic [STATUS_CNT_WIDTH-1:0]  mismatch_count;
        logic [STATUS_CNT_WIDTH-1:0]  first_mismatch_idx;
    } status_t;

endpackage

// File: rtl/checker_watchdog.sv
// rtl/checker_watchdog.sv - idle-cycle watchdog for the stream checker
//
// Purpose : counts consecutive enabled cycles and flags expiry on the
//           TIMEOUT_CYCLES-th one.
// Ports   : clk, rst_n (sync, active-low)
//           clear   - restart the idle count (wins over enable)
//           enable  - this cycle is an idle cycle
//           expired - this idle cycle is the TIMEOUT_CYCLES-th in a row
module checker_watchdog
    import axis_checker_pkg::*;
#(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 220000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_WIDTH-1:0] LIMIT_M1 = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            idle_cnt <= '0;
        end else if (enable) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Combinational so the owner can register its timeout flag on the same
    // edge that completes the idle window.
    assign expired = enable && (idle_cnt == LIMIT_M1);

endmodule

// File: rtl/axis_stream_checker.sv
// rtl/axis_stream_checker.sv - compares a DUT AXI-Stream against a golden stream
//
// Purpose : joins the DUT output stream with a golden reference stream, counts
//           and checksums words, records mismatches, and checks stream length
//           and idle timeout.
// Ports   : clk, rst_n (sync, active-low), start (arm pulse)
//           axis_dut_data/valid/last, axis_dut_ready - DUT stream
//           axis_ref_data/valid, axis_ref_ready      - golden stream
//           busy, finished, failed, length_error, timeout - status flags
//           word_count, mismatch_count, first_mismatch_idx, checksum - results
module axis_stream_checker
    import axis_checker_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int EXPECTED_WORDS = 4881,
    parameter int TIMEOUT_CYCLES = 220000,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] axis_dut_data,
    input  logic                  axis_dut_valid,
    input  logic                  axis_dut_last,
    output logic                  axis_dut_ready,
    input  logic [DATA_WIDTH-1:0] axis_ref_data,
    input  logic                  axis_ref_valid,
    output logic                  axis_ref_ready,
    output logic                  busy,
    output logic                  finished,
    output logic                  failed,
    output logic                  length_error,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic [CNT_WIDTH-1:0]  first_mismatch_idx,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(EXPECTED_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    checker_state_e       state;
    status_flags_t        flags;
    logic [CNT_WIDTH-1:0] wc;
    logic [CNT_WIDTH-1:0] mc;
    logic [CNT_WIDTH-1:0] fmi;
    logic [DATA_WIDTH-1:0] cs;

    logic in_run;
    logic xfer;
    logic mismatch;
    logic wd_expired;

    assign in_run   = (state == ST_RUN);
    assign xfer     = in_run && axis_dut_valid && axis_ref_valid;
    assign mismatch = (axis_dut_data != axis_ref_data);

    // Join: each side is ready only when the other side has a word, so a
    // word is never consumed from one stream without its partner.
    assign axis_dut_ready = in_run && axis_ref_valid;
    assign axis_ref_ready = in_run && axis_dut_valid;

    checker_watchdog #(
        .CNT_WIDTH      (CNT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_run || xfer),
        .enable  (in_run && !xfer),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            flags <= '0;
            wc    <= '0;
            mc    <= '0;
            fmi   <= '1;
            cs    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        flags      <= '0;
                        flags.busy <= 1'b1;
                        wc         <= '0;
                        mc         <= '0;
                        fmi        <= '1;
                        cs         <= '0;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        wc <= wc + 1'b1;
                        cs <= cs + axis_dut_data;
                        if (mismatch) begin
                            flags.failed <= 1'b1;
                            if (mc != CNT_MAX) begin
                                mc <= mc + 1'b1;
                            end
                            if (mc == '0) begin
                                fmi <= wc;
                            end
                        end
                        if (axis_dut_last && (wc == LAST_IDX)) begin
                            state          <= ST_DONE;
                            flags.busy     <= 1'b0;
                            flags.finished <= 1'b1;
                        end else if (axis_dut_last || (wc == LAST_IDX)) begin
                            state              <= ST_DONE;
                            flags.busy         <= 1'b0;
                            flags.finished     <= 1'b1;
                            flags.failed       <= 1'b1;
                            flags.length_error <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        state          <= ST_DONE;
                        flags.busy     <= 1'b0;
                        flags.finished <= 1'b1;
                        flags.failed   <= 1'b1;
                        flags.timeout  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    flags <= '0;
                end
            endcase
        end
    end

    assign busy               = flags.busy;
    assign finished           = flags.finished;
    assign failed             = flags.failed;
    assign length_error       = flags.length_error;
    assign timeout            = flags.timeout;
    assign word_count         = wc;
    assign mismatch_count     = mc;
    assign first_mismatch_idx = fmi;
    assign checksum           = cs;

endmodule

// File: tb/tb_axis_stream_checker.sv
// tb/tb_axis_stream_checker.sv - self-checking bench for axis_stream_checker
module tb_axis_stream_checker;

    localparam int N  = 8;
    localparam int TO = 16;
    localparam int DW = 64;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] axis_dut_data = '0;
    logic          axis_dut_valid = 1'b0;
    logic          axis_dut_last = 1'b0;
    logic          axis_dut_ready;
    logic [DW-1:0] axis_ref_data = '0;
    logic          axis_ref_valid = 1'b0;
    logic          axis_ref_ready;
    logic          busy, finished, failed, length_error, timeout;
    logic [CW-1:0] word_count, mismatch_count, first_mismatch_idx;
    logic [DW-1:0] checksum;

    always #5 clk = ~clk;

    axis_stream_checker #(
        .DATA_WIDTH     (DW),
        .EXPECTED_WORDS (N),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .axis_dut_data      (axis_dut_data),
        .axis_dut_valid     (axis_dut_valid),
        .axis_dut_last      (axis_dut_last),
        .axis_dut_ready     (axis_dut_ready),
        .axis_ref_data      (axis_ref_data),
        .axis_ref_valid     (axis_ref_valid),
        .axis_ref_ready     (axis_ref_ready),
        .busy               (busy),
        .finished           (finished),
        .failed             (failed),
        .length_error       (length_error),
        .timeout            (timeout),
        .word_count         (word_count),
        .mismatch_count     (mismatch_count),
        .first_mismatch_idx (first_mismatch_idx),
        .checksum           (checksum)
    );

    int tests = 0;
    int fails = 0;

    // Scenario description
    logic [DW-1:0] dut_w [N];
    logic [DW-1:0] ref_w [N];
    int last_at;
    int dut_stop;
    int gap_pct;
    int start_pulse_cyc;

    // Reference model: results implied by the sequence of joined words
    bit            running;
    int            idle;
    bit            exp_finished, exp_failed, exp_len, exp_timeout;
    logic [CW-1:0] exp_wc, exp_mc, exp_fmi;
    logic [DW-1:0] exp_cs;

    task automatic model_clear();
        running      = 0;
        idle         = 0;
        exp_finished = 0;
        exp_failed   = 0;
        exp_len      = 0;
        exp_timeout  = 0;
        exp_wc       = '0;
        exp_mc       = '0;
        exp_fmi      = '1;
        exp_cs       = '0;
    endtask

    task automatic model_step(input bit xfer, input logic [DW-1:0] d, input logic [DW-1:0] r,
                              input bit last);
        if (xfer) begin
            if (d != r) begin
                if (exp_mc == 0) exp_fmi = exp_wc;
                if (exp_mc != '1) exp_mc = exp_mc + 1;
                exp_failed = 1;
            end
            exp_wc = exp_wc + 1;
            exp_cs = exp_cs + d;
            idle   = 0;
            if (last || exp_wc == N) begin
                running      = 0;
                exp_finished = 1;
                if (!(last && exp_wc == N)) begin
                    exp_len    = 1;
                    exp_failed = 1;
                end
            end
        end else begin
            idle = idle + 1;
            if (idle == TO) begin
                running      = 0;
                exp_timeout  = 1;
                exp_failed   = 1;
                exp_finished = 1;
            end
        end
    endtask

    task automatic fill_seq();
        for (int i = 0; i < N; i++) begin
            dut_w[i] = DW'(i + 1);
            ref_w[i] = DW'(i + 1);
        end
        last_at         = N - 1;
        dut_stop        = N;
        gap_pct         = 0;
        start_pulse_cyc = -1;
    endtask

    task automatic do_start();
        @(negedge clk);
        axis_dut_valid = 1'b0;
        axis_ref_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        model_clear();
        running = 1;
    endtask

    // Drives both streams cycle by cycle, tracking busy and ready behaviour
    // against the model, until the run has been over for a few cycles.
    task automatic run_engine(input int max_cycles, input bit allow_unfinished);
        int cyc = 0;
        int post = 0;
        int idx = 0;
        int di;
        bit xfer;
        while (post < 3 && cyc < max_cycles) begin
            @(negedge clk);
            tests++;
            if (busy !== running) begin
                fails++;
                $display("FAIL busy_track cyc=%0d: got %0b expected %0b", cyc, busy, running);
            end
            di = (idx < N) ? idx : N - 1;
            axis_dut_valid = (idx < dut_stop) && (idx < N) && ($urandom_range(99) >= gap_pct);
            axis_ref_valid = (idx < N) && ($urandom_range(99) >= gap_pct);
            axis_dut_data  = dut_w[di];
            axis_ref_data  = ref_w[di];
            axis_dut_last  = (idx == last_at);
            start          = (cyc == start_pulse_cyc);
            #1;
            tests++;
            if (axis_dut_ready !== (running && axis_ref_valid)) begin
                fails++;
                $display("FAIL dut_ready cyc=%0d: got %0b expected %0b", cyc, axis_dut_ready,
                         running && axis_ref_valid);
            end
            tests++;
            if (axis_ref_ready !== (running && axis_dut_valid)) begin
                fails++;
                $display("FAIL ref_ready cyc=%0d: got %0b expected %0b", cyc, axis_ref_ready,
                         running && axis_dut_valid);
            end
            xfer = running && axis_dut_valid && axis_ref_valid;
            @(posedge clk);
            if (running) model_step(xfer, axis_dut_data, axis_ref_data, axis_dut_last);
            if (xfer) idx++;
            if (!running) post++;
            cyc++;
        end
        start = 1'b0;
        if (!allow_unfinished && post < 3) begin
            tests++;
            fails++;
            $display("FAIL run_budget: got %0d cycles without completion expected done", cyc);
        end
        @(negedge clk);
        axis_dut_valid = 1'b0;
        axis_ref_valid = 1'b0;
        axis_dut_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        axis_dut_valid = 1'b1;
        axis_ref_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({busy, finished, failed, length_error, timeout} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, finished, failed, length_error, timeout});
        end
        tests++;
        if ({word_count, mismatch_count, checksum} !== '0) begin
            fails++;
            $display("FAIL reset_counters: got wc=%0d mc=%0d cs=%0d expected 0", word_count,
                     mismatch_count, checksum);
        end
        tests++;
        if (first_mismatch_idx !== '1) begin
            fails++;
            $display("FAIL reset_fmi: got %h expected ffffffff", first_mismatch_idx);
        end
        tests++;
        if ({axis_dut_ready, axis_ref_ready} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ready: got %b expected 00", {axis_dut_ready, axis_ref_ready});
        end
        rst_n = 1'b1;
        axis_dut_valid = 1'b0;
        axis_ref_valid = 1'b0;
        model_clear();
    endtask

    task automatic test_clean_run();
        fill_seq();
        do_start();
        run_engine(200, 0);
        tests++;
        if ({finished, failed, length_error, timeout} !== 4'b1000) begin
            fails++;
            $display("FAIL clean_flags: got %b expected 1000", {finished, failed, length_error, timeout});
        end
        tests++;
        if (word_count !== 8) begin
            fails++;
            $display("FAIL clean_wc: got %0d expected 8", word_count);
        end
        tests++;
        if (checksum !== 36) begin
            fails++;
            $display("FAIL clean_checksum: got %0d expected 36", checksum);
        end
    endtask

    task automatic test_mismatch();
        fill_seq();
        dut_w[2] = 64'd300;
        dut_w[5] = 64'd600;
        do_start();
        run_engine(200, 0);
        tests++;
        if (mismatch_count !== 2 || first_mismatch_idx !== 2) begin
            fails++;
            $display("FAIL mismatch_counts: got mc=%0d fmi=%0d expected mc=2 fmi=2", mismatch_count,
                     first_mismatch_idx);
        end
        tests++;
        if ({finished, failed, length_error} !== 3'b110) begin
            fails++;
            $display("FAIL mismatch_flags: got %b expected 110", {finished, failed, length_error});
        end
        tests++;
        if (checksum !== exp_cs) begin
            fails++;
            $display("FAIL mismatch_checksum: got %0d expected %0d", checksum, exp_cs);
        end
    endtask

    task automatic test_early_last();
        fill_seq();
        last_at = 4;
        gap_pct = 20;
        do_start();
        run_engine(300, 0);
        tests++;
        if ({finished, failed, length_error, timeout} !== 4'b1110) begin
            fails++;
            $display("FAIL early_last_flags: got %b expected 1110",
                     {finished, failed, length_error, timeout});
        end
        tests++;
        if (word_count !== 5) begin
            fails++;
            $display("FAIL early_last_wc: got %0d expected 5", word_count);
        end
    endtask

    task automatic test_missing_last();
        fill_seq();
        last_at = -1;
        do_start();
        run_engine(200, 0);
        tests++;
        if ({finished, failed, length_error} !== 3'b111 || word_count !== 8) begin
            fails++;
            $display("FAIL missing_last: got flags=%b wc=%0d expected flags=111 wc=8",
                     {finished, failed, length_error}, word_count);
        end
    endtask

    task automatic test_timeout();
        fill_seq();
        dut_stop = 3;
        do_start();
        run_engine(200, 0);
        tests++;
        if ({finished, failed, timeout, length_error} !== 4'b1110) begin
            fails++;
            $display("FAIL timeout_flags: got %b expected 1110", {finished, failed, timeout, length_error});
        end
        tests++;
        if (word_count !== 3 || checksum !== 6) begin
            fails++;
            $display("FAIL timeout_counts: got wc=%0d cs=%0d expected wc=3 cs=6", word_count, checksum);
        end
    endtask

    task automatic test_start_ignored();
        fill_seq();
        start_pulse_cyc = 4;
        do_start();
        run_engine(200, 0);
        tests++;
        if (word_count !== 8 || checksum !== 36 || failed !== 1'b0) begin
            fails++;
            $display("FAIL start_ignored: got wc=%0d cs=%0d failed=%0b expected wc=8 cs=36 failed=0",
                     word_count, checksum, failed);
        end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 6; r++) begin
            fill_seq();
            gap_pct = 30;
            for (int i = 0; i < N; i++) begin
                dut_w[i] = {$urandom, $urandom};
                ref_w[i] = ($urandom_range(3) == 0) ? {$urandom, $urandom} : dut_w[i];
            end
            do_start();
            run_engine(600, 0);
            tests++;
            if ({finished, failed, length_error, timeout} !== {exp_finished, exp_failed, exp_len, exp_timeout}) begin
                fails++;
                $display("FAIL random_flags run=%0d: got %b expected %b", r,
                         {finished, failed, length_error, timeout},
                         {exp_finished, exp_failed, exp_len, exp_timeout});
            end
            tests++;
            if (word_count !== exp_wc || mismatch_count !== exp_mc || first_mismatch_idx !== exp_fmi) begin
                fails++;
                $display("FAIL random_counts run=%0d: got wc=%0d mc=%0d fmi=%h expected wc=%0d mc=%0d fmi=%h",
                         r, word_count, mismatch_count, first_mismatch_idx, exp_wc, exp_mc, exp_fmi);
            end
            tests++;
            if (checksum !== exp_cs) begin
                fails++;
                $display("FAIL random_checksum run=%0d: got %h expected %h", r, checksum, exp_cs);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        fill_seq();
        gap_pct = 30;
        dut_w[1] = 64'd99;
        do_start();
        run_engine(6, 1);
        rst_n = 1'b0;
        axis_dut_valid = 1'b1;
        axis_ref_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        tests++;
        if ({busy, finished, failed, length_error, timeout} !== 5'b0) begin
            fails++;
            $display("FAIL midreset_flags: got %b expected 00000",
                     {busy, finished, failed, length_error, timeout});
        end
        tests++;
        if ({word_count, mismatch_count, checksum} !== '0 || first_mismatch_idx !== '1) begin
            fails++;
            $display("FAIL midreset_counters: got wc=%0d mc=%0d cs=%0d fmi=%h expected 0 0 0 ffffffff",
                     word_count, mismatch_count, checksum, first_mismatch_idx);
        end
        tests++;
        if ({axis_dut_ready, axis_ref_ready} !== 2'b00) begin
            fails++;
            $display("FAIL midreset_ready: got %b expected 00", {axis_dut_ready, axis_ref_ready});
        end
        axis_dut_valid = 1'b0;
        axis_ref_valid = 1'b0;
        fill_seq();
        gap_pct = 25;
        do_start();
        run_engine(600, 0);
        tests++;
        if ({finished, failed} !== 2'b10 || word_count !== 8 || checksum !== 36) begin
            fails++;
            $display("FAIL second_run: got fin=%0b failed=%0b wc=%0d cs=%0d expected 1 0 8 36",
                     finished, failed, word_count, checksum);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clean_run();
        test_mismatch();
        test_early_last();
        test_missing_last();
        test_timeout();
        test_start_ignored();
        test_random_runs();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
